// File: rtl/tim_mem_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// tim_mem_arbiter_pkg
// Shared types and defaults for the itim/dtim backing-memory arbiter.
//   arb_state_type : arbiter FSM encoding (IDLE, GNT_I, GNT_D), 2 bits
//   last_type      : which requester was served most recently
//   mem_in_type    : requester -> memory request bundle (mirrors the core's
//                    configure definition)
//   mem_out_type   : memory -> requester response bundle
// ---------------------------------------------------------------------------
package tim_mem_arbiter_pkg;

  localparam int unsigned HOLD_LIMIT_DEFAULT = 8;
  localparam int unsigned CNT_WIDTH_DEFAULT  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } arb_state_type;

  typedef enum logic {
    LAST_I = 1'b0,
    LAST_D = 1'b1
  } last_type;

  typedef struct packed {
    logic        mem_valid;
    logic        mem_instr;
    logic        mem_fence;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
  } mem_in_type;

  typedef struct packed {
    logic        mem_ready;
    logic [31:0] mem_rdata;
  } mem_out_type;

endpackage

// File: rtl/tim_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tim_mem_arbiter
// Shares one backing-memory port between the itim and dtim memory sides.
// A grant is kept across burst beats; after hold_limit ready beats the grant
// is handed to a waiting requester on the next beat-free cycle.
//
// Ports:
//   clk      : clock
//   rst      : synchronous reset, active-low
//   imem_in  : request from itim        imem_out : response to itim
//   dmem_in  : request from dtim        dmem_out : response to dtim
//   mem_in   : request to memory        mem_out  : response from memory
//
// Parameters:
//   hold_limit : max consecutive ready beats while the other side waits (>= 1)
//   cnt_width  : beat counter width, 2**cnt_width > hold_limit
//
// Configuration:
//   TIM_ARB_RR_EN defined   : simultaneous requests in IDLE go to the side
//                             not served last (round-robin)
//   TIM_ARB_RR_EN undefined : dtim wins simultaneous requests in IDLE
// ---------------------------------------------------------------------------
module tim_mem_arbiter
  import tim_mem_arbiter_pkg::*;
#(
  parameter int unsigned hold_limit = HOLD_LIMIT_DEFAULT,
  parameter int unsigned cnt_width  = CNT_WIDTH_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  mem_in_type  imem_in,
  output mem_out_type imem_out,
  input  mem_in_type  dmem_in,
  output mem_out_type dmem_out,
  output mem_in_type  mem_in,
  input  mem_out_type mem_out
);

  localparam logic [cnt_width-1:0] CNT_CAP = cnt_width'(hold_limit);

  arb_state_type          state_q, state_d;
  logic [cnt_width-1:0]   cnt_q, cnt_d;
  last_type               last_q, last_d;
  logic                   tie_to_d;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    mem_in   = '0;
    imem_out = '0;
    dmem_out = '0;

`ifdef TIM_ARB_RR_EN
    tie_to_d = (last_q == LAST_I);
`else
    tie_to_d = 1'b1;
`endif

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (imem_in.mem_valid && dmem_in.mem_valid) begin
          state_d = tie_to_d ? GNT_D : GNT_I;
        end else if (dmem_in.mem_valid) begin
          state_d = GNT_D;
        end else if (imem_in.mem_valid) begin
          state_d = GNT_I;
        end
      end

      GNT_I: begin
        mem_in   = imem_in;
        imem_out = mem_out;
        if (mem_out.mem_ready && (cnt_q != CNT_CAP)) begin
          cnt_d = cnt_q + 1'b1;
        end
        if (!imem_in.mem_valid) begin
          state_d = IDLE;
          cnt_d   = '0;
          last_d  = LAST_I;
        end else if ((cnt_q == CNT_CAP) && dmem_in.mem_valid && !mem_out.mem_ready) begin
          // Hand over only on a beat-free cycle so the capping beat reaches
          // its owner; itim keeps valid and resumes at its current address.
          state_d = GNT_D;
          cnt_d   = '0;
          last_d  = LAST_I;
        end
      end

      GNT_D: begin
        mem_in   = dmem_in;
        dmem_out = mem_out;
        if (mem_out.mem_ready && (cnt_q != CNT_CAP)) begin
          cnt_d = cnt_q + 1'b1;
        end
        if (!dmem_in.mem_valid) begin
          state_d = IDLE;
          cnt_d   = '0;
          last_d  = LAST_D;
        end else if ((cnt_q == CNT_CAP) && imem_in.mem_valid && !mem_out.mem_ready) begin
          state_d = GNT_I;
          cnt_d   = '0;
          last_d  = LAST_D;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbours.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= LAST_I;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: tb/tb_tim_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_tim_mem_arbiter
// Directed bench for tim_mem_arbiter. Two simple requester models (itim,
// dtim) issue one beat per ready and advance their address by 4; a memory
// model answers after mem_lat wait cycles with rdata = addr ^ KEY.
// ---------------------------------------------------------------------------
module tb_tim_mem_arbiter;
  import tim_mem_arbiter_pkg::*;

  localparam logic [31:0] KEY = 32'h5A5A_0000;

  logic        clk = 1'b0;
  logic        rst;
  mem_in_type  imem_in, dmem_in, mem_in;
  mem_out_type imem_out, dmem_out, mem_out;

  tim_mem_arbiter dut (
    .clk      (clk),
    .rst      (rst),
    .imem_in  (imem_in),
    .imem_out (imem_out),
    .dmem_in  (dmem_in),
    .dmem_out (dmem_out),
    .mem_in   (mem_in),
    .mem_out  (mem_out)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          i_left, d_left;
  logic [31:0] i_addr, d_addr;
  int          mem_lat, wait_n, cyc;
  logic        rst_lvl;
  int          route_err, data_err;
  bit          beat_owner[$];   // 0 = itim, 1 = dtim
  logic [31:0] beat_addr[$];
  int          beat_cyc[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic int n_beats(input bit owner);
    int n;
    n = 0;
    foreach (beat_owner[k]) if (beat_owner[k] == owner) n++;
    return n;
  endfunction

  task automatic new_test();
    beat_owner.delete();
    beat_addr.delete();
    beat_cyc.delete();
    cyc    = 0;
    wait_n = 0;
  endtask

  // One clock cycle: drive at negedge, model memory, observe before posedge.
  task automatic run_cycle();
    @(negedge clk);
    cyc++;
    rst = rst_lvl;
    imem_in           = '0;
    imem_in.mem_valid = (i_left > 0);
    imem_in.mem_instr = 1'b1;
    imem_in.mem_addr  = i_addr;
    dmem_in           = '0;
    dmem_in.mem_valid = (d_left > 0);
    dmem_in.mem_fence = d_addr[4];
    dmem_in.mem_addr  = d_addr;
    dmem_in.mem_wdata = ~d_addr;
    dmem_in.mem_wstrb = 4'hF;
    mem_out           = '0;
    #1;
    if (rst && mem_in.mem_valid && (wait_n >= mem_lat)) begin
      mem_out.mem_ready = 1'b1;
      mem_out.mem_rdata = mem_in.mem_addr ^ KEY;
    end
    #1;
    if (mem_in.mem_valid) begin
      if (mem_in.mem_instr) begin
        if (mem_in !== imem_in || imem_out !== mem_out || dmem_out !== '0) route_err++;
      end else begin
        if (mem_in !== dmem_in || dmem_out !== mem_out || imem_out !== '0) route_err++;
      end
    end else if (imem_out !== '0 || dmem_out !== '0) begin
      route_err++;
    end
    if (imem_out.mem_ready) begin
      beat_owner.push_back(1'b0);
      beat_addr.push_back(i_addr);
      beat_cyc.push_back(cyc);
      if (imem_out.mem_rdata !== (i_addr ^ KEY)) data_err++;
      i_left--;
      i_addr += 32'd4;
    end
    if (dmem_out.mem_ready) begin
      beat_owner.push_back(1'b1);
      beat_addr.push_back(d_addr);
      beat_cyc.push_back(cyc);
      if (dmem_out.mem_rdata !== (d_addr ^ KEY)) data_err++;
      d_left--;
      d_addr += 32'd4;
    end
    if (mem_in.mem_valid && !mem_out.mem_ready) wait_n++;
    else wait_n = 0;
  endtask

  task automatic run_until_done(input int budget);
    int n;
    n = 0;
    while ((i_left > 0 || d_left > 0) && n < budget) begin
      run_cycle();
      n++;
    end
    check("drain_timeout", 32'((i_left > 0) || (d_left > 0)), 32'd0);
  endtask

  task automatic settle();
    run_cycle();
    run_cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; rst_lvl = 1'b0;
    imem_in = '0; dmem_in = '0; mem_out = '0;
    i_left = 0; d_left = 0; i_addr = '0; d_addr = '0;
    mem_lat = 0; route_err = 0; data_err = 0;
    new_test();

    // Reset: both sides request while rst is low; nothing may be forwarded.
    i_left = 1; d_left = 1; i_addr = 32'h10; d_addr = 32'h20;
    run_cycle();
    run_cycle();
    check("rst_mem_valid",   32'(mem_in.mem_valid),   32'd0);
    check("rst_imem_ready",  32'(imem_out.mem_ready), 32'd0);
    check("rst_dmem_rdata",  dmem_out.mem_rdata,      32'd0);
    check("rst_state",       32'(dut.state_q),        32'(IDLE));
    check("rst_cnt",         32'(dut.cnt_q),          32'd0);
    i_left = 0; d_left = 0; rst_lvl = 1'b1;
    settle();

    // T1: single itim request, memory ready after 2 wait cycles.
    new_test();
    mem_lat = 2; i_left = 1; i_addr = 32'h100;
    run_cycle();
    check("t1_idle_fwd", 32'(mem_in.mem_valid), 32'd0);
    run_cycle();
    check("t1_fwd_valid", 32'(mem_in.mem_valid), 32'd1);
    check("t1_fwd_addr",  mem_in.mem_addr,       32'h100);
    run_cycle();
    run_cycle();
    run_cycle();
    check("t1_drop_fwd", 32'(mem_in.mem_valid), 32'd0);
    run_cycle();
    check("t1_state_idle", 32'(dut.state_q), 32'(IDLE));
    check("t1_i_beats", 32'(n_beats(1'b0)), 32'd1);
    check("t1_d_beats", 32'(n_beats(1'b1)), 32'd0);
    check("t1_beat_cyc", 32'(beat_cyc[0]), 32'd4);
    settle();

    // T2: simultaneous requests with itim last served -> dtim first either way.
    new_test();
    mem_lat = 0; i_left = 2; i_addr = 32'h400; d_left = 2; d_addr = 32'h800;
    run_cycle();
    check("t2_idle_fwd", 32'(mem_in.mem_valid), 32'd0);
    run_until_done(40);
    check("t2_first_owner", 32'(beat_owner[0]), 32'd1);
    check("t2_third_owner", 32'(beat_owner[2]), 32'd0);
    check("t2_d_last_cyc",  32'(beat_cyc[1]),   32'd3);
    check("t2_i_first_cyc", 32'(beat_cyc[2]),   32'd6);
    settle();

    // T3: dtim served last, then a tie.
    new_test();
    d_left = 1; d_addr = 32'hC00;
    run_until_done(20);
    settle();
    new_test();
    i_left = 1; i_addr = 32'h500; d_left = 1; d_addr = 32'hD00;
    run_until_done(20);
`ifdef TIM_ARB_RR_EN
    check("t3_tie_owner", 32'(beat_owner[0]), 32'd0);
`else
    check("t3_tie_owner", 32'(beat_owner[0]), 32'd1);
`endif
    settle();

    // T4: 16-beat dtim refill, itim arrives while dtim holds the port.
    new_test();
    mem_lat = 1; d_left = 16; d_addr = 32'h2000;
    run_cycle();
    i_left = 4; i_addr = 32'h300;
    run_until_done(200);
    check("t4_total_beats", 32'(beat_owner.size()), 32'd20);
    check("t4_owner7",  32'(beat_owner[7]),  32'd1);
    check("t4_owner8",  32'(beat_owner[8]),  32'd0);
    check("t4_owner12", 32'(beat_owner[12]), 32'd1);
    check("t4_cap_beat_cyc", 32'(beat_cyc[7]), 32'd17);
    check("t4_i_first_cyc",  32'(beat_cyc[8]), 32'd19);
    check("t4_i_first_addr", beat_addr[8],     32'h300);
    check("t4_d_resume_cyc", 32'(beat_cyc[12]), 32'd29);
    check("t4_d_resume_addr", beat_addr[12],   32'h2020);
    check("t4_d_last_addr",  beat_addr[19],    32'h203C);
    check("t4_d_beats", 32'(n_beats(1'b1)), 32'd16);
    settle();

    // T5: reset for one cycle in the middle of an itim burst.
    new_test();
    mem_lat = 0; i_left = 6; i_addr = 32'h600;
    run_cycle();
    run_cycle();
    run_cycle();
    check("t5_pre_beats", 32'(n_beats(1'b0)), 32'd2);
    rst_lvl = 1'b0;
    run_cycle();
    rst_lvl = 1'b1; i_left = 0; d_left = 1; d_addr = 32'hE00;
    run_cycle();
    check("t5_state", 32'(dut.state_q), 32'(IDLE));
    check("t5_cnt",   32'(dut.cnt_q),   32'd0);
    check("t5_fwd",   32'(mem_in.mem_valid), 32'd0);
    run_until_done(20);
    check("t5_d_beats", 32'(n_beats(1'b1)), 32'd1);
    check("t5_d_addr",  beat_addr[beat_addr.size()-1], 32'hE00);
    settle();

    // T6: granted itim drops valid on the cycle dtim raises valid.
    new_test();
    mem_lat = 0; i_left = 2; i_addr = 32'h700;
    run_cycle();
    run_cycle();
    run_cycle();
    d_left = 2; d_addr = 32'hF00;
    run_cycle();
    check("t6_drop_fwd", 32'(mem_in.mem_valid), 32'd0);
    run_cycle();
    check("t6_idle_fwd", 32'(mem_in.mem_valid), 32'd0);
    check("t6_idle_state", 32'(dut.state_q), 32'(IDLE));
    run_until_done(20);
    check("t6_d_owner", 32'(beat_owner[2]), 32'd1);
    check("t6_d_cyc",   32'(beat_cyc[2]),   32'd6);
    settle();

    check("routing_errors", 32'(route_err), 32'd0);
    check("data_errors",    32'(data_err),  32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
